print_arbiter_mc: RTL and testbench

Parametrised multi-core print/output arbiter: collects print words from `NUM_CORES` Elpis cores, picks one per cycle with round-robin priority, and buffers each word with its core ID in a FIFO. The host side (logic-analyzer / Wishbone readback in the chip controller) drains the FIFO with a valid/ack handshake. It is the successor to the single-core, unbuffered output arbiter and sits between the cores' print ports and the chip-controller host interface.

---
 rtl/elpis_io_pkg.sv | 15 +
 rtl/print_fifo.sv | 78 +++++++
 rtl/print_arbiter_mc.sv | 131 +++++++++++++
 tb/tb_print_arbiter_mc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elpis_io_pkg.sv
// Shared definitions for the Elpis core I/O blocks.
//   DEFAULT_DATA_W    - default print word width
//   DEFAULT_NUM_CORES - default number of requesting cores
//   id_width(n)       - width of a core ID for n cores (at least one bit)
package elpis_io_pkg;

    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_NUM_CORES = 2;

    // A single core still needs a one-bit ID field in the FIFO entry.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/print_fifo.sv
// Synchronous FIFO holding {core_id, word} print entries.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   push_i        - write push_data_i at the tail
//   push_data_i   - entry to write
//   pop_i         - advance the head (ignored while empty)
//   clear_i       - flush; overrides push and pop in the same cycle
//   head_o        - entry at the head, zero while empty
//   full_o        - no free entry
//   empty_o       - no valid entry
//   count_o       - occupancy
module print_fifo #(
    parameter  int WIDTH = 33,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH) + 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // The extra MSB on each pointer is a lap bit: equal indices with
    // differing lap bits means the writer is a full lap ahead.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign count_o = CNT_W'(wr_ptr_q - rd_ptr_q);

    assign do_pop  = pop_i && !empty_o && !clear_i;
    // A full FIFO still accepts a write when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; stale contents are hidden by the empty gate below.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
    end

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule

// File: rtl/print_arbiter_mc.sv
// Multi-core print arbiter: round-robin selection among requesting cores,
// one accepted word per cycle buffered with its core ID, drained by the host
// through a valid/ack handshake.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   req            - per-core print request (level)
//   data_in        - core i word at [i*DATA_W +: DATA_W]
//   is_ready       - registered one-cycle accept pulse per core
//   clear          - synchronous flush of the FIFO and round-robin pointer
//   print_valid    - FIFO holds at least one entry
//   print_data     - head word
//   print_core_id  - head word's source core
//   print_ack      - host pop, honoured only while print_valid
//   fifo_count     - occupancy
//   overflow_seen  - sticky: an eligible request found the FIFO full
module print_arbiter_mc
    import elpis_io_pkg::*;
#(
    parameter  int NUM_CORES  = DEFAULT_NUM_CORES,
    parameter  int DATA_W     = DEFAULT_DATA_W,
    parameter  int FIFO_DEPTH = 4,
    localparam int ID_W       = id_width(NUM_CORES),
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES*DATA_W-1:0] data_in,
    output logic [NUM_CORES-1:0]        is_ready,
    input  logic                        clear,
    output logic                        print_valid,
    output logic [DATA_W-1:0]           print_data,
    output logic [ID_W-1:0]             print_core_id,
    input  logic                        print_ack,
    output logic [CNT_W-1:0]            fifo_count,
    output logic                        overflow_seen
);

    localparam int ENTRY_W = ID_W + DATA_W;
    localparam logic [ID_W-1:0] LAST_CORE = ID_W'(NUM_CORES - 1);

    logic [NUM_CORES-1:0] is_ready_q, is_ready_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic                 overflow_q, overflow_d;

    logic [NUM_CORES-1:0] eligible;
    logic [DATA_W-1:0]    core_word [NUM_CORES];
    logic [ID_W-1:0]      winner;
    logic                 winner_found;
    logic                 grant;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_head;
    int                   idx;

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core_word
        assign core_word[gi] = data_in[gi*DATA_W +: DATA_W];
    end

    // A core that saw its pulse this cycle is still reacting to it; masking
    // it prevents the same word being accepted twice.
    assign eligible = req & ~is_ready_q;

    assign pop   = !fifo_empty && print_ack && !clear;
    assign grant = winner_found && (!fifo_full || pop) && !clear;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        winner       = last_grant_q;
        winner_found = 1'b0;
        idx          = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_CORES;
            if (!winner_found && eligible[idx]) begin
                winner_found = 1'b1;
                winner       = ID_W'(idx);
            end
        end
    end

    always_comb begin
        is_ready_d   = '0;
        last_grant_d = last_grant_q;
        if (clear) begin
            last_grant_d = LAST_CORE;
        end else if (grant) begin
            is_ready_d[winner] = 1'b1;
            last_grant_d       = winner;
        end
    end

    // A flush is not a stall, so a request present during clear does not count.
    assign overflow_d = overflow_q ||
                        ((|eligible) && fifo_full && !pop && !clear);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_ready_q   <= '0;
            last_grant_q <= LAST_CORE;
            overflow_q   <= 1'b0;
        end else begin
            is_ready_q   <= is_ready_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    print_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (grant),
        .push_data_i ({winner, core_word[winner]}),
        .pop_i       (pop),
        .clear_i     (clear),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign is_ready      = is_ready_q;
    assign overflow_seen = overflow_q;
    assign print_valid   = !fifo_empty;
    assign print_data    = fifo_head[DATA_W-1:0];
    assign print_core_id = fifo_head[DATA_W +: ID_W];

endmodule

// File: tb/tb_print_arbiter_mc.sv
// Directed bench for print_arbiter_mc: a 2-core instance for the main
// sequence and a 3-core instance for the reset-mid-stream case.
module tb_print_arbiter_mc;

    logic        clk;
    int          checks;
    int          errors;

    // 2-core instance
    logic        rst_n;
    logic [1:0]  req;
    logic [63:0] data_in;
    logic [1:0]  is_ready;
    logic        clear;
    logic        print_valid;
    logic [31:0] print_data;
    logic [0:0]  print_core_id;
    logic        print_ack;
    logic [2:0]  fifo_count;
    logic        overflow_seen;

    // 3-core instance
    logic        rst_n2;
    logic [2:0]  req2;
    logic [95:0] data_in2;
    logic [2:0]  is_ready2;
    logic        clear2;
    logic        print_valid2;
    logic [31:0] print_data2;
    logic [1:0]  print_core_id2;
    logic        print_ack2;
    logic [2:0]  fifo_count2;
    logic        overflow_seen2;

    print_arbiter_mc #(.NUM_CORES(2), .DATA_W(32), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .data_in       (data_in),
        .is_ready      (is_ready),
        .clear         (clear),
        .print_valid   (print_valid),
        .print_data    (print_data),
        .print_core_id (print_core_id),
        .print_ack     (print_ack),
        .fifo_count    (fifo_count),
        .overflow_seen (overflow_seen)
    );

    print_arbiter_mc #(.NUM_CORES(3), .DATA_W(32), .FIFO_DEPTH(4)) dut3 (
        .clk           (clk),
        .rst_n         (rst_n2),
        .req           (req2),
        .data_in       (data_in2),
        .is_ready      (is_ready2),
        .clear         (clear2),
        .print_valid   (print_valid2),
        .print_data    (print_data2),
        .print_core_id (print_core_id2),
        .print_ack     (print_ack2),
        .fifo_count    (fifo_count2),
        .overflow_seen (overflow_seen2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req       = '0;
        data_in   = '0;
        clear     = 1'b0;
        print_ack = 1'b0;
        rst_n2    = 1'b0;
        req2      = '0;
        data_in2  = '0;
        clear2    = 1'b0;
        print_ack2 = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_is_ready", 64'(is_ready), 0);
        chk("rst_valid",    64'(print_valid), 0);
        chk("rst_data",     64'(print_data), 0);
        chk("rst_id",       64'(print_core_id), 0);
        chk("rst_count",    64'(fifo_count), 0);
        chk("rst_overflow", 64'(overflow_seen), 0);
        rst_n  = 1'b1;
        rst_n2 = 1'b1;
        step();

        // Single request from core 0
        req = 2'b01;
        data_in[31:0] = 32'hDEADBEEF;
        step();
        chk("t1_is_ready", 64'(is_ready), 2'b01);
        chk("t1_valid",    64'(print_valid), 1);
        chk("t1_data",     64'(print_data), 32'hDEADBEEF);
        chk("t1_id",       64'(print_core_id), 0);
        chk("t1_count",    64'(fifo_count), 1);
        req = 2'b00;
        print_ack = 1'b1;
        step();
        chk("t1_pop_count", 64'(fifo_count), 0);
        chk("t1_pop_valid", 64'(print_valid), 0);
        chk("t1_pop_rdy",   64'(is_ready), 0);
        step();  // ack while empty must be ignored
        chk("t1_ack_empty", 64'(fifo_count), 0);
        print_ack = 1'b0;

        // Both cores requesting, no ack: alternate 0,1,0,1 then stall full
        clear = 1'b1;
        step();
        clear = 1'b0;
        req = 2'b11;
        data_in = {32'h000000B1, 32'h000000A0};
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t2_is_ready", 64'(is_ready), (k < 4) ? ((k % 2 == 0) ? 1 : 2) : 0);
            chk("t2_count",    64'(fifo_count), (k < 4) ? k + 1 : 4);
            chk("t2_overflow", 64'(overflow_seen), (k >= 4) ? 1 : 0);
        end
        chk("t2_head_id",   64'(print_core_id), 0);
        chk("t2_head_data", 64'(print_data), 32'hA0);

        // Full with ack held: push+pop each cycle, order preserved
        print_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_is_ready", 64'(is_ready), (k % 2 == 0) ? 1 : 2);
            chk("t3_count",    64'(fifo_count), 4);
            chk("t3_head_id",  64'(print_core_id), (k % 2 == 0) ? 1 : 0);
            chk("t3_head_data", 64'(print_data), (k % 2 == 0) ? 32'hB1 : 32'hA0);
        end
        req = 2'b00;
        print_ack = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_count",    64'(fifo_count), 0);
        chk("clr_valid",    64'(print_valid), 0);
        chk("clr_data",     64'(print_data), 0);
        chk("clr_overflow", 64'(overflow_seen), 1);

        // Fill 1..4, drain, refill 5..8 across pointer wrap
        for (int b = 0; b < 2; b++) begin
            for (int k = 1; k <= 4; k++) begin
                data_in[31:0] = 32'(b * 4 + k);
                req = 2'b01;
                step();
                chk("t4_fill_rdy",   64'(is_ready), 1);
                chk("t4_fill_count", 64'(fifo_count), k);
                req = 2'b00;
                step();
                chk("t4_gap_rdy",    64'(is_ready), 0);
            end
            print_ack = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                chk("t4_valid", 64'(print_valid), 1);
                chk("t4_data",  64'(print_data), b * 4 + k);
                step();
                chk("t4_drain_count", 64'(fifo_count), 4 - k);
            end
            print_ack = 1'b0;
            chk("t4_gap_valid", 64'(print_valid), 0);
        end

        // Clear with a pending request and ack; next grant goes to core 0
        req = 2'b11;
        data_in = {32'h00000022, 32'h00000011};
        step();
        chk("t5_rdy_a",   64'(is_ready), 2'b10);
        chk("t5_count_a", 64'(fifo_count), 1);
        step();
        chk("t5_rdy_b",   64'(is_ready), 2'b01);
        chk("t5_count_b", 64'(fifo_count), 2);
        clear = 1'b1;
        req = 2'b10;
        print_ack = 1'b1;
        step();
        chk("t5_clr_count", 64'(fifo_count), 0);
        chk("t5_clr_rdy",   64'(is_ready), 0);
        chk("t5_clr_valid", 64'(print_valid), 0);
        clear = 1'b0;
        print_ack = 1'b0;
        req = 2'b11;
        step();
        chk("t5_next_rdy",  64'(is_ready), 2'b01);
        chk("t5_next_id",   64'(print_core_id), 0);
        chk("t5_next_data", 64'(print_data), 32'h11);
        chk("t5_next_count", 64'(fifo_count), 1);
        req = 2'b00;
        clear = 1'b1;
        step();
        clear = 1'b0;

        // 3 cores: reset pulsed mid-stream with 3 entries queued
        req2 = 3'b110;
        data_in2 = {32'h000000C2, 32'h000000C1, 32'h000000C0};
        step();
        chk("t6_rdy_a", 64'(is_ready2), 3'b010);
        step();
        chk("t6_rdy_b", 64'(is_ready2), 3'b100);
        step();
        chk("t6_rdy_c", 64'(is_ready2), 3'b010);
        chk("t6_count", 64'(fifo_count2), 3);
        req2 = 3'b000;
        rst_n2 = 1'b0;
        #1;
        chk("t6_rst_rdy",   64'(is_ready2), 0);
        chk("t6_rst_valid", 64'(print_valid2), 0);
        chk("t6_rst_data",  64'(print_data2), 0);
        chk("t6_rst_id",    64'(print_core_id2), 0);
        chk("t6_rst_count", 64'(fifo_count2), 0);
        chk("t6_rst_ovf",   64'(overflow_seen2), 0);
        step();
        chk("t6_held_count", 64'(fifo_count2), 0);
        rst_n2 = 1'b1;
        req2 = 3'b111;
        step();
        chk("t6_post_rdy",   64'(is_ready2), 3'b001);
        chk("t6_post_id",    64'(print_core_id2), 0);
        chk("t6_post_data",  64'(print_data2), 32'hC0);
        chk("t6_post_count", 64'(fifo_count2), 1);
        req2 = 3'b000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
